// File: rtl/cluster_sched_pkg.sv
// Shared constants, frame type and FSM states for the cluster readout scheduler.
// Optional feature macro: CLUSTER_SCHED_BX_TAG_EN adds a 12-bit BX tag to each frame.
package cluster_sched_pkg;

    localparam int          ADR_W     = 11;
    localparam int          NUM_SLOTS = 8;
    localparam logic [10:0] ADR_MAX   = 11'd1535;
    localparam logic [10:0] ADR_EMPTY = 11'h7FF;
    localparam logic [11:0] BX_MAX    = 12'd3563;

    // One buffered BX frame: all eight addresses plus the occupancy mask
    typedef struct packed {
        logic [NUM_SLOTS*ADR_W-1:0] adrs;
        logic [NUM_SLOTS-1:0]       mask;
`ifdef CLUSTER_SCHED_BX_TAG_EN
        logic [11:0]                bx;
`endif
    } frame_t;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    // A slot carries a hit only when its address is a real strip (< 1536)
    function automatic logic [NUM_SLOTS-1:0] occupancy(input logic [NUM_SLOTS*ADR_W-1:0] a);
        logic [NUM_SLOTS-1:0] m;
        m = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            m[k] = (a[k*ADR_W +: ADR_W] <= ADR_MAX);
        end
        return m;
    endfunction

endpackage

// File: rtl/cluster_readout_scheduler_prio.sv
// Combinational lowest-set-bit encoder over eight request bits.
// Not affected by CLUSTER_SCHED_BX_TAG_EN.
module slot_prio_enc8 (
    input  logic [7:0] i_req,
    output logic [2:0] o_index,
    output logic       o_any,
    output logic [7:0] o_onehot
);

    // Scan from the top so the lowest set bit wins; onehot isolates that same bit
    always_comb begin
        o_any    = |i_req;
        o_onehot = i_req & (~i_req + 8'd1);
        o_index  = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (i_req[k]) begin
                o_index = 3'(k);
            end
        end
    end

endmodule

// File: rtl/cluster_readout_scheduler.sv
// Drains per-BX strip address frames onto a ready/valid stream, one hit per clock.
// Frames are buffered whole in a small FIFO; frames arriving at a full FIFO are
// dropped and counted. Optional feature macro: CLUSTER_SCHED_BX_TAG_EN (BX tagging).
module cluster_readout_scheduler #(
    parameter int ADR_W       = 11,
    parameter int FRAME_DEPTH = 2,
    parameter int OVF_W       = 16
) (
    input  logic               clock4x,
    input  logic               reset_n,
    input  logic               frame_valid,
    input  logic [8*ADR_W-1:0] adrs,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ADR_W-1:0]   out_adr,
    output logic [2:0]         out_slot,
    output logic               out_last,
    output logic               ovf_pulse,
    output logic [OVF_W-1:0]   ovf_cnt
`ifdef CLUSTER_SCHED_BX_TAG_EN
    ,
    input  logic               bc0,
    output logic [11:0]        out_bx
`endif
);
    import cluster_sched_pkg::*;

    localparam int         PW      = $clog2(FRAME_DEPTH);
    localparam logic [PW:0] DEPTH_L = (PW+1)'(FRAME_DEPTH);

    state_t           r_state, w_next_state;
    frame_t           r_fifo [FRAME_DEPTH];
    logic [PW:0]      r_wr_ptr, r_rd_ptr;
    logic [PW:0]      w_count, w_count_after, w_rd_next;
    logic [7:0]       r_work, w_work_after, w_next_work, w_in_mask;
    frame_t           w_in_frame, w_next_head;
    logic             w_accept, w_frame_done, w_full, w_write, w_drop;
    logic [2:0]       w_enc_idx;
    logic             w_enc_any;
    logic [7:0]       w_enc_onehot;

    logic             r_out_valid, r_out_last, r_ovf_pulse;
    logic [ADR_W-1:0] r_out_adr;
    logic [2:0]       r_out_slot;
    logic [OVF_W-1:0] r_ovf_cnt;

`ifdef CLUSTER_SCHED_BX_TAG_EN
    logic [11:0]      r_bx_cnt, w_bx_next, r_out_bx;
`endif

    // Incoming frame, FIFO occupancy and the write/drop decision (head is freed before the write)
    always_comb begin
        w_in_mask  = occupancy(adrs);
        w_in_frame = '0;
        w_in_frame.adrs = adrs;
        w_in_frame.mask = w_in_mask;
`ifdef CLUSTER_SCHED_BX_TAG_EN
        w_bx_next = bc0 ? 12'd0 : ((r_bx_cnt == BX_MAX) ? 12'd0 : r_bx_cnt + 12'd1);
        w_in_frame.bx = w_bx_next;
`endif
        w_accept      = r_out_valid & out_ready;
        w_frame_done  = w_accept & r_out_last;
        w_count       = r_wr_ptr - r_rd_ptr;
        w_full        = (w_count == DEPTH_L);
        w_write       = frame_valid & (|w_in_mask) & (~w_full | w_frame_done);
        w_drop        = frame_valid & (|w_in_mask) & w_full & ~w_frame_done;
        w_count_after = w_count - {{PW{1'b0}}, w_frame_done};
        w_rd_next     = r_rd_ptr + {{PW{1'b0}}, w_frame_done};
        w_work_after  = w_accept ? (r_work & ~(8'b1 << r_out_slot)) : r_work;
    end

    // Next state plus which frame and remaining-slot mask will be presented next cycle
    always_comb begin
        w_next_state = r_state;
        w_next_head  = r_fifo[r_rd_ptr[PW-1:0]];
        w_next_work  = w_work_after;
        case (r_state)
            S_IDLE: begin
                w_next_work = '0;
                if (w_write) begin
                    w_next_state = S_DRAIN;
                    w_next_head  = w_in_frame;
                    w_next_work  = w_in_mask;
                end
            end
            S_DRAIN: begin
                if (w_frame_done) begin
                    if (w_count_after != '0) begin
                        w_next_head = r_fifo[w_rd_next[PW-1:0]];
                        w_next_work = w_next_head.mask;
                    end else if (w_write) begin
                        w_next_head = w_in_frame;
                        w_next_work = w_in_mask;
                    end else begin
                        w_next_state = S_IDLE;
                        w_next_work  = '0;
                    end
                end
            end
            default: begin
                w_next_state = S_IDLE;
                w_next_work  = '0;
            end
        endcase
    end

    slot_prio_enc8 u_prio (
        .i_req    (w_next_work),
        .o_index  (w_enc_idx),
        .o_any    (w_enc_any),
        .o_onehot (w_enc_onehot)
    );

    // State, pointers, working mask, registered outputs and the overflow counter
    always_ff @(posedge clock4x or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_work      <= '0;
            r_out_valid <= 1'b0;
            r_out_adr   <= '0;
            r_out_slot  <= '0;
            r_out_last  <= 1'b0;
            r_ovf_pulse <= 1'b0;
            r_ovf_cnt   <= '0;
        end else begin
            r_state     <= w_next_state;
            r_wr_ptr    <= r_wr_ptr + {{PW{1'b0}}, w_write};
            r_rd_ptr    <= w_rd_next;
            r_work      <= w_next_work;
            r_out_valid <= w_enc_any;
            r_out_last  <= w_enc_any && (w_next_work == w_enc_onehot);
            if (w_enc_any) begin
                r_out_adr  <= w_next_head.adrs[w_enc_idx*ADR_W +: ADR_W];
                r_out_slot <= w_enc_idx;
            end
            r_ovf_pulse <= w_drop;
            if (w_drop && (r_ovf_cnt != '1)) begin
                r_ovf_cnt <= r_ovf_cnt + 1'b1;
            end
        end
    end

    // Frame storage needs no reset; the pointers define what is valid
    always_ff @(posedge clock4x) begin
        if (w_write) begin
            r_fifo[r_wr_ptr[PW-1:0]] <= w_in_frame;
        end
    end

`ifdef CLUSTER_SCHED_BX_TAG_EN
    // BX counter advances on every frame strobe and the head frame's tag follows its addresses
    always_ff @(posedge clock4x or negedge reset_n) begin
        if (!reset_n) begin
            r_bx_cnt <= '0;
            r_out_bx <= '0;
        end else begin
            if (frame_valid) begin
                r_bx_cnt <= w_bx_next;
            end
            if (w_enc_any) begin
                r_out_bx <= w_next_head.bx;
            end
        end
    end

    assign out_bx = r_out_bx;
`endif

    assign out_valid = r_out_valid;
    assign out_adr   = r_out_adr;
    assign out_slot  = r_out_slot;
    assign out_last  = r_out_last;
    assign ovf_pulse = r_ovf_pulse;
    assign ovf_cnt   = r_ovf_cnt;

endmodule

// File: tb/tb_cluster_readout_scheduler.sv
// Self-checking bench for cluster_readout_scheduler with a scoreboard of expected hits.
// BX tag checks are compiled only when CLUSTER_SCHED_BX_TAG_EN is defined.
module tb_cluster_readout_scheduler;

    logic        clock4x = 1'b0;
    logic        reset_n = 1'b0;
    logic        frame_valid = 1'b0;
    logic [87:0] adrs = {8{11'h7FF}};
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [10:0] out_adr;
    logic [2:0]  out_slot;
    logic        out_last;
    logic        ovf_pulse;
    logic [15:0] ovf_cnt;
    logic        bc0 = 1'b0;
    logic [11:0] out_bx;

    typedef struct {
        logic [10:0] adr;
        logic [2:0]  slot;
        logic        last;
        logic [11:0] bx;
    } exp_t;

    exp_t        sbq[$];
    int          assertCount = 0;
    int          failCount   = 0;
    logic [11:0] tbBx = 12'd0;
    logic [87:0] emptyFrame = {8{11'h7FF}};

    always #5 clock4x = ~clock4x;

    cluster_readout_scheduler #(
        .ADR_W       (11),
        .FRAME_DEPTH (2),
        .OVF_W       (16)
    ) dut (
        .clock4x     (clock4x),
        .reset_n     (reset_n),
        .frame_valid (frame_valid),
        .adrs        (adrs),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_adr     (out_adr),
        .out_slot    (out_slot),
        .out_last    (out_last),
        .ovf_pulse   (ovf_pulse),
        .ovf_cnt     (ovf_cnt)
`ifdef CLUSTER_SCHED_BX_TAG_EN
        ,
        .bc0         (bc0),
        .out_bx      (out_bx)
`endif
    );

`ifndef CLUSTER_SCHED_BX_TAG_EN
    assign out_bx = 12'd0;
`endif

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        assertCount++;
        assert (obs === expv) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [87:0] setSlot(input logic [87:0] f, input int k, input logic [10:0] v);
        logic [87:0] r;
        r = f;
        r[k*11 +: 11] = v;
        return r;
    endfunction

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clock4x);
        #2;
    endtask

    // Drive one frame strobe (called at posedge+2) and push the hits it should produce
    task automatic applyStimulus(input logic [87:0] f, input logic b0, input bit expectDrop);
        int   lastK;
        exp_t e;
        if (b0) tbBx = 12'd0;
        else    tbBx = (tbBx == 12'd3563) ? 12'd0 : tbBx + 12'd1;
        lastK = -1;
        for (int k = 0; k < 8; k++) begin
            if (f[k*11 +: 11] < 11'd1536) lastK = k;
        end
        if (!expectDrop) begin
            for (int k = 0; k < 8; k++) begin
                if (f[k*11 +: 11] < 11'd1536) begin
                    e.adr  = f[k*11 +: 11];
                    e.slot = 3'(k);
                    e.last = (k == lastK);
                    e.bx   = tbBx;
                    sbq.push_back(e);
                end
            end
        end
        frame_valid = 1'b1;
        adrs        = f;
        bc0         = b0;
        @(posedge clock4x);
        #2;
        frame_valid = 1'b0;
        bc0         = 1'b0;
        adrs        = emptyFrame;
    endtask

    task automatic waitDrain(input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            if (sbq.size() == 0) break;
            waitCycles(1);
        end
        checkOutput(tag, sbq.size(), 0);
    endtask

    // Every accepted transfer is compared against the head of the scoreboard
    always @(negedge clock4x) begin
        if (reset_n && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                checkOutput("unexpected_out", out_valid, 0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                checkOutput("out_adr", out_adr, e.adr);
                checkOutput("out_slot", out_slot, e.slot);
                checkOutput("out_last", out_last, e.last);
`ifdef CLUSTER_SCHED_BX_TAG_EN
                checkOutput("out_bx", out_bx, e.bx);
`endif
            end
        end
    end

    // Hard time limit so the run can never hang
    initial begin
        #400000;
        $display("[TB] FAIL watchdog expired assertions=%0d failures=%0d", assertCount, failCount);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [87:0] f, f8a, f8b, f8c, fc;

        // Reset values
        #12;
        checkOutput("rst_valid", out_valid, 0);
        checkOutput("rst_adr", out_adr, 0);
        checkOutput("rst_slot", out_slot, 0);
        checkOutput("rst_last", out_last, 0);
        checkOutput("rst_ovf_pulse", ovf_pulse, 0);
        checkOutput("rst_ovf_cnt", ovf_cnt, 0);
        @(posedge clock4x);
        #2;
        reset_n = 1'b1;

        // Two-hit frame, one-cycle latency, then back to idle
        f = setSlot(setSlot(emptyFrame, 1, 11'd12), 5, 11'd900);
        applyStimulus(f, 1'b0, 1'b0);
        checkOutput("lat_valid", out_valid, 1);
        waitDrain(20, "drain_t1");
        checkOutput("idle_after_t1", out_valid, 0);

        // Empty frame is ignored and not counted as overflow
        applyStimulus(emptyFrame, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("empty_no_valid", out_valid, 0);
            waitCycles(1);
        end
        checkOutput("empty_no_ovf", ovf_cnt, 0);

        // Backpressure: three hits with 1535 occupied and 1536 empty at the boundary
        out_ready = 1'b0;
        f = setSlot(setSlot(setSlot(setSlot(emptyFrame, 0, 11'd5), 2, 11'd1536), 3, 11'd700), 7, 11'd1535);
        applyStimulus(f, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checkOutput("hold_valid", out_valid, 1);
            checkOutput("hold_adr", out_adr, 5);
            checkOutput("hold_slot", out_slot, 0);
            waitCycles(1);
        end
        out_ready = 1'b1;
        waitDrain(20, "drain_t3");

        // Overflow: third full frame at a full two-deep FIFO is dropped
        out_ready = 1'b0;
        f8a = '0; f8b = '0; f8c = '0;
        for (int k = 0; k < 8; k++) begin
            f8a[k*11 +: 11] = 11'(100 + k);
            f8b[k*11 +: 11] = 11'(200 + k);
            f8c[k*11 +: 11] = 11'(300 + k);
        end
        applyStimulus(f8a, 1'b0, 1'b0);
        waitCycles(3);
        applyStimulus(f8b, 1'b0, 1'b0);
        waitCycles(3);
        applyStimulus(f8c, 1'b0, 1'b1);
        checkOutput("ovf_pulse_hi", ovf_pulse, 1);
        checkOutput("ovf_cnt_1", ovf_cnt, 1);
        waitCycles(1);
        checkOutput("ovf_pulse_lo", ovf_pulse, 0);
        checkOutput("ovf_cnt_hold", ovf_cnt, 1);

        // Free-before-write: last slot of the head accepted as a new frame lands on the full FIFO
        out_ready = 1'b1;
        waitCycles(7);
        fc = setSlot(setSlot(emptyFrame, 2, 11'd33), 4, 11'd1000);
        applyStimulus(fc, 1'b0, 1'b0);
        checkOutput("fbw_no_pulse", ovf_pulse, 0);
        checkOutput("fbw_cnt", ovf_cnt, 1);
        checkOutput("fbw_no_bubble", out_valid, 1);
        checkOutput("fbw_next_adr", out_adr, 200);
        waitDrain(60, "drain_t5");
        checkOutput("fbw_cnt_final", ovf_cnt, 1);

        // Asynchronous reset in the middle of a drain discards everything
        applyStimulus(f8a, 1'b0, 1'b0);
        waitCycles(2);
        #1;
        reset_n = 1'b0;
        #1;
        checkOutput("arst_valid", out_valid, 0);
        checkOutput("arst_adr", out_adr, 0);
        checkOutput("arst_slot", out_slot, 0);
        checkOutput("arst_last", out_last, 0);
        sbq.delete();
        tbBx = 12'd0;
        @(posedge clock4x);
        #2;
        reset_n = 1'b1;
        f = setSlot(emptyFrame, 6, 11'd42);
        applyStimulus(f, 1'b0, 1'b0);
        checkOutput("post_rst_valid", out_valid, 1);
        checkOutput("post_rst_adr", out_adr, 42);
        waitDrain(20, "drain_t6");
        waitCycles(4);
        checkOutput("post_rst_idle", out_valid, 0);

`ifdef CLUSTER_SCHED_BX_TAG_EN
        // BX tags: bc0 frame gets 0, next gets 1, and the tag wraps after 3564 strobes
        applyStimulus(setSlot(emptyFrame, 0, 11'd10), 1'b1, 1'b0);
        waitCycles(3);
        applyStimulus(setSlot(emptyFrame, 1, 11'd11), 1'b0, 1'b0);
        waitDrain(20, "drain_bx");
        applyStimulus(setSlot(emptyFrame, 2, 11'd20), 1'b1, 1'b0);
        for (int i = 0; i < 3563; i++) begin
            applyStimulus(emptyFrame, 1'b0, 1'b0);
        end
        checkOutput("bx_model_wrap", tbBx, 3563);
        applyStimulus(setSlot(emptyFrame, 3, 11'd21), 1'b0, 1'b0);
        waitDrain(20, "drain_wrap");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
